m14k_sleep_ctl: RTL and testbench
=================================

M14K_SLEEP_CTL -- requirements
Module: m14k_sleep_ctl

Interface
REQ-001 SHALL have parameter WAKE_DLY, default 4: gfclk cycles from wake detection to sleep_ack deassertion; legal range 1..15.
REQ-002 SHALL have parameter DRAIN_MAX, default 255: drain timeout in cycles; legal range 1..255; used only with the timeout feature.
REQ-003 SHALL have port gfclk, input, 1: free-running core clock; the single clock of this block.
REQ-004 SHALL have port greset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port mpc_wait_req, input, 1: single-cycle pulse when a WAIT instruction graduates.
REQ-006 SHALL have port mpc_pipe_idle, input, 1: pipeline empty, no outstanding loads or stores.
REQ-007 SHALL have port biu_idle, input, 1: bus interface has no pending transaction.
REQ-008 SHALL have port int_pend, input, 1: unmasked interrupt pending.
REQ-009 SHALL have port SI_NMI, input, 1: non-maskable interrupt, level.
REQ-010 SHALL have port ej_dbg_req, input, 1: EJTAG debug request.
REQ-011 SHALL have port gscanmode, input, 1: scan mode; forces the clock to run.
REQ-012 SHALL have port cpz_goodnight, output, 1: clock-gate request to the clock module.
REQ-013 SHALL have port sleep_ack, output, 1: core in sleep; drives SI_Sleep.
REQ-014 SHALL have port wake_pulse, output, 1: one-cycle pulse when the pipeline may restart.
REQ-015 SHALL have port sleep_abort, output, 1: one-cycle pulse when a drain is abandoned.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, SLEEP, WAKE, with all outputs registered.
REQ-017 RUN SHALL go to DRAIN on mpc_wait_req=1 when no wake source is active; otherwise it SHALL stay in RUN.
REQ-018 A wake source SHALL be int_pend | SI_NMI | ej_dbg_req.
REQ-019 DRAIN SHALL go to SLEEP in the first cycle where mpc_pipe_idle & biu_idle = 1.
REQ-020 DRAIN SHALL go to RUN, with a sleep_abort pulse, if a wake source is asserted before the idle condition is met.
REQ-021 If the wake source and the idle condition occur in the same cycle, the wake source SHALL win (go to RUN, pulse sleep_abort).
REQ-022 On entry to SLEEP, cpz_goodnight and sleep_ack SHALL assert in the next cycle: 1 cycle of latency from the idle condition.
REQ-023 SLEEP SHALL go to WAKE on any wake source, and SHALL deassert cpz_goodnight in the next cycle.
REQ-024 WAKE SHALL load a 4-bit down-counter with WAKE_DLY, decrement it every cycle, and return to RUN when the counter reaches 0.
REQ-025 On the WAKE-to-RUN transition, sleep_ack SHALL deassert and wake_pulse SHALL pulse once.
REQ-026 A wake source that deasserts during WAKE SHALL NOT return the FSM to SLEEP; WAKE always completes.
REQ-027 mpc_wait_req pulses in DRAIN, SLEEP or WAKE SHALL be ignored.
REQ-028 gscanmode=1 SHALL force cpz_goodnight=0 combinationally, regardless of state; the FSM SHALL keep advancing normally.

Reset
REQ-029 Asserting greset SHALL asynchronously force state=RUN, counters=0, and cpz_goodnight, sleep_ack, wake_pulse and sleep_abort all 0.
REQ-030 If greset asserts mid-SLEEP, cpz_goodnight SHALL clear without waiting for a clock edge.
REQ-031 Release of greset SHALL be synchronous to gfclk; the first transition out of RUN SHALL occur no earlier than the first edge after release.

Configuration
REQ-032 The timeout feature SHALL be controlled by macro M14K_SLEEP_TIMEOUT_EN.
REQ-033 When M14K_SLEEP_TIMEOUT_EN is defined, DRAIN SHALL count cycles in an 8-bit counter; on reaching DRAIN_MAX without the idle condition, the FSM SHALL go to RUN and pulse sleep_abort.
REQ-034 When M14K_SLEEP_TIMEOUT_EN is undefined, DRAIN SHALL wait indefinitely, and the drain counter and DRAIN_MAX logic SHALL be absent.

Structure
REQ-035 State encodings (2-bit: RUN=0, DRAIN=1, SLEEP=2, WAKE=3) and WAKE_DLY/DRAIN_MAX defaults SHALL reside in the shared constants header m14k_const.vh.
REQ-036 The block SHALL instantiate one sub-module, m14k_sleep_cnt: a parameterized-width loadable down-counter with load, en and zero flag, used for both the WAKE and DRAIN counters.
REQ-037 The block SHALL contain no clock buffers; gating stays in the clock module.

Verification
REQ-038 Bench SHALL cover: wait pulse with pipe_idle=biu_idle=1 -> goodnight=1 two cycles after the pulse; int_pend at +10 -> goodnight=0 next cycle; wake_pulse at WAKE_DLY=4 cycles later.
REQ-039 Bench SHALL cover: wait pulse with biu_idle=0 and int_pend raised 3 cycles later -> sleep_abort pulse, state RUN, goodnight never asserted.
REQ-040 Bench SHALL cover: idle condition and SI_NMI in the same cycle during DRAIN -> sleep_abort=1, no SLEEP entry.
REQ-041 Bench SHALL cover: with M14K_SLEEP_TIMEOUT_EN defined, DRAIN_MAX=8, biu_idle held at 0 -> sleep_abort exactly 8 cycles after DRAIN entry; with the macro undefined -> DRAIN held for 100 cycles.
REQ-042 Bench SHALL cover: greset pulsed mid-SLEEP between clock edges -> goodnight=0 immediately, sleep_ack=0, FSM in RUN.
REQ-043 Bench SHALL cover: gscanmode=1 during SLEEP -> goodnight=0 while sleep_ack stays 1; gscanmode=0 -> goodnight=1 again.

Source files
------------

// File: rtl/m14k_sleep_ctl_pkg.sv
// Shared constants for the M14K sleep controller: state encodings, counter widths and
// parameter defaults, plus the wake-source reduction used by the FSM.
package m14k_sleep_ctl_pkg;

    localparam int WAKE_DLY_DEF  = 4;
    localparam int DRAIN_MAX_DEF = 255;
    localparam int WAKE_CNT_W    = 4;
    localparam int DRAIN_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } sleep_state_e;

    function automatic logic wake_source(input logic int_pend,
                                         input logic nmi,
                                         input logic dbg_req);
        return int_pend | nmi | dbg_req;
    endfunction

endpackage

// File: rtl/m14k_sleep_cnt.sv
// Loadable down-counter shared by the wake-delay and drain-timeout timers; saturates at zero.
// zero_o flags the edge on which the count lands on zero, so the owner can leave that cycle.
module m14k_sleep_cnt #(
    parameter int W = 4
) (
    input  logic         gfclk_i,
    input  logic         greset_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    assign zero_o = (cnt_d == '0);

    always_ff @(posedge gfclk_i or posedge greset_i) begin
        if (greset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m14k_sleep_ctl.sv
// M14K sleep/wake sequencer: drains the pipe on WAIT, requests clock gating, restarts after WAKE_DLY.
// Optional drain timeout is built only when M14K_SLEEP_TIMEOUT_EN is defined.
//
// state | meaning
// RUN   | core executing; a WAIT with no wake source starts a drain
// DRAIN | waiting for pipe and bus idle; a wake source (or timeout) aborts back to RUN
// SLEEP | clock gate requested, sleep_ack high; any wake source starts the wake delay
// WAKE  | clock running again, counting WAKE_DLY cycles before releasing the pipe
module m14k_sleep_ctl
    import m14k_sleep_ctl_pkg::*;
#(
    parameter int WAKE_DLY  = WAKE_DLY_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic gfclk,
    input  logic greset,
    input  logic mpc_wait_req,
    input  logic mpc_pipe_idle,
    input  logic biu_idle,
    input  logic int_pend,
    input  logic SI_NMI,
    input  logic ej_dbg_req,
    input  logic gscanmode,
    output logic cpz_goodnight,
    output logic sleep_ack,
    output logic wake_pulse,
    output logic sleep_abort
);

    if (WAKE_DLY < 1 || WAKE_DLY > (1 << WAKE_CNT_W) - 1 ||
        DRAIN_MAX < 1 || DRAIN_MAX > (1 << DRAIN_CNT_W) - 1) begin : g_param_chk
        $error("m14k_sleep_ctl: WAKE_DLY or DRAIN_MAX outside the counter range");
    end

    localparam logic [WAKE_CNT_W-1:0] WAKE_LD = WAKE_CNT_W'(WAKE_DLY);

    sleep_state_e state_q;
    sleep_state_e state_d;
    logic         goodnight_q, goodnight_d;
    logic         sleep_ack_q, sleep_ack_d;
    logic         wake_pulse_q, wake_pulse_d;
    logic         sleep_abort_q, sleep_abort_d;
    logic [1:0]   release_q;
    logic         run_en;
    logic         wake_src;
    logic         pipe_quiet;
    logic         wcnt_load, wcnt_en, wcnt_zero;

    // Reset asserts asynchronously but the FSM only starts once release has crossed two edges.
    always_ff @(posedge gfclk or posedge greset) begin
        if (greset) begin
            release_q <= 2'b00;
        end else begin
            release_q <= {release_q[0], 1'b1};
        end
    end

    assign run_en     = release_q[1];
    assign wake_src   = wake_source(int_pend, SI_NMI, ej_dbg_req);
    assign pipe_quiet = mpc_pipe_idle & biu_idle;

    m14k_sleep_cnt #(
        .W (WAKE_CNT_W)
    ) u_wake_cnt (
        .gfclk_i  (gfclk),
        .greset_i (greset),
        .load_i   (wcnt_load),
        .val_i    (WAKE_LD),
        .en_i     (wcnt_en),
        .zero_o   (wcnt_zero)
    );

`ifdef M14K_SLEEP_TIMEOUT_EN
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LD = DRAIN_CNT_W'(DRAIN_MAX);

    logic dcnt_load, dcnt_en, dcnt_zero;

    m14k_sleep_cnt #(
        .W (DRAIN_CNT_W)
    ) u_drain_cnt (
        .gfclk_i  (gfclk),
        .greset_i (greset),
        .load_i   (dcnt_load),
        .val_i    (DRAIN_LD),
        .en_i     (dcnt_en),
        .zero_o   (dcnt_zero)
    );
`endif

    always_comb begin
        state_d       = state_q;
        sleep_abort_d = 1'b0;
        wake_pulse_d  = 1'b0;
        wcnt_load     = 1'b0;
        wcnt_en       = 1'b0;
`ifdef M14K_SLEEP_TIMEOUT_EN
        dcnt_load     = 1'b0;
        dcnt_en       = 1'b0;
`endif
        if (run_en) begin
            unique case (state_q)
                ST_RUN: begin
                    if (mpc_wait_req && !wake_src) begin
                        state_d = ST_DRAIN;
`ifdef M14K_SLEEP_TIMEOUT_EN
                        dcnt_load = 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
`ifdef M14K_SLEEP_TIMEOUT_EN
                    dcnt_en = 1'b1;
`endif
                    // A wake source wins over an idle pipe seen in the same cycle.
                    if (wake_src) begin
                        state_d       = ST_RUN;
                        sleep_abort_d = 1'b1;
                    end else if (pipe_quiet) begin
                        state_d = ST_SLEEP;
`ifdef M14K_SLEEP_TIMEOUT_EN
                    end else if (dcnt_zero) begin
                        state_d       = ST_RUN;
                        sleep_abort_d = 1'b1;
`endif
                    end
                end
                ST_SLEEP: begin
                    if (wake_src) begin
                        state_d   = ST_WAKE;
                        wcnt_load = 1'b1;
                    end
                end
                ST_WAKE: begin
                    wcnt_en = 1'b1;
                    if (wcnt_zero) begin
                        state_d      = ST_RUN;
                        wake_pulse_d = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        goodnight_d = (state_d == ST_SLEEP);
        sleep_ack_d = (state_d == ST_SLEEP) || (state_d == ST_WAKE);
    end

    always_ff @(posedge gfclk or posedge greset) begin
        if (greset) begin
            state_q       <= ST_RUN;
            goodnight_q   <= 1'b0;
            sleep_ack_q   <= 1'b0;
            wake_pulse_q  <= 1'b0;
            sleep_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            goodnight_q   <= goodnight_d;
            sleep_ack_q   <= sleep_ack_d;
            wake_pulse_q  <= wake_pulse_d;
            sleep_abort_q <= sleep_abort_d;
        end
    end

    // Scan must always see a running clock, so the gate request is masked outside the register.
    assign cpz_goodnight = goodnight_q & ~gscanmode;
    assign sleep_ack     = sleep_ack_q;
    assign wake_pulse    = wake_pulse_q;
    assign sleep_abort   = sleep_abort_q;

endmodule

// File: tb/tb_m14k_sleep_ctl.sv
// Self-checking bench for m14k_sleep_ctl: each episode is one WAIT, with expected waveforms
// derived from cycle arithmetic on when idle, wake and scan windows occur.
module tb_m14k_sleep_ctl;
    import m14k_sleep_ctl_pkg::*;

    localparam int WAKE_DLY  = 4;
    localparam int DRAIN_MAX = 8;
    localparam int NEVER     = 100000;
`ifdef M14K_SLEEP_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic gfclk, greset;
    logic mpc_wait_req, mpc_pipe_idle, biu_idle;
    logic int_pend, SI_NMI, ej_dbg_req, gscanmode;
    logic cpz_goodnight, sleep_ack, wake_pulse, sleep_abort;

    int vectors     = 0;
    int miscompares = 0;
    int ep_num      = 0;
    int ep_cyc      = 0;

    m14k_sleep_ctl #(
        .WAKE_DLY  (WAKE_DLY),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .gfclk         (gfclk),
        .greset        (greset),
        .mpc_wait_req  (mpc_wait_req),
        .mpc_pipe_idle (mpc_pipe_idle),
        .biu_idle      (biu_idle),
        .int_pend      (int_pend),
        .SI_NMI        (SI_NMI),
        .ej_dbg_req    (ej_dbg_req),
        .gscanmode     (gscanmode),
        .cpz_goodnight (cpz_goodnight),
        .sleep_ack     (sleep_ack),
        .wake_pulse    (wake_pulse),
        .sleep_abort   (sleep_abort)
    );

    initial gfclk = 1'b0;
    always #5 gfclk = ~gfclk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s ep=%0d cyc=%0d observed=%b expected=%b", tag, ep_num, ep_cyc, obs, exp);
        end
    endtask

    function automatic bit in_win(input int c, input int start, input int len);
        return (c >= start) && (c < start + len);
    endfunction

    task automatic clear_inputs();
        mpc_wait_req  = 1'b0;
        mpc_pipe_idle = 1'b0;
        biu_idle      = 1'b0;
        int_pend      = 1'b0;
        SI_NMI        = 1'b0;
        ej_dbg_req    = 1'b0;
        gscanmode     = 1'b0;
    endtask

    // Cycle 0 carries the WAIT pulse. Pipe+bus idle from idle_at on; wake sources (mask src =
    // {dbg,nmi,int}) active for wake_len cycles from wake_at; scan high over [scan_lo, scan_hi].
    // Entered and left just after a rising edge.
    task automatic episode(input int idle_at, input int wake_at, input int wake_len,
                           input logic [2:0] src, input int scan_lo, input int scan_hi,
                           input bit noise, input int rst_at);
        int  d;
        int  s;
        int  e;
        bit  abort;
        bit  scan;
        int  r;
        ep_num++;
        d = 1;
        while (!(in_win(d, wake_at, wake_len) || d >= idle_at ||
                 (TIMEOUT && d == DRAIN_MAX)) && d < 5000) begin
            d++;
        end
        abort = in_win(d, wake_at, wake_len) || (d < idle_at);
        s     = d + 1;
        e     = abort ? d + 1 : wake_at + WAKE_DLY + 1;
        for (int c = 0; c <= e + 1; c++) begin
            ep_cyc       = c;
            mpc_wait_req = (c == 0) || (noise && c >= 1 && c < e && $urandom_range(0, 3) == 0);
            if (c >= idle_at) begin
                mpc_pipe_idle = 1'b1;
                biu_idle      = 1'b1;
            end else begin
                r             = $urandom_range(0, 2);
                mpc_pipe_idle = r[0];
                biu_idle      = r[1];
            end
            {ej_dbg_req, SI_NMI, int_pend} = in_win(c, wake_at, wake_len) ? src : 3'b000;
            scan      = (c >= scan_lo) && (c <= scan_hi);
            gscanmode = scan;
            @(negedge gfclk);
            chk("goodnight",  cpz_goodnight, !abort && c >= s && c <= wake_at && !scan);
            chk("sleep_ack",  sleep_ack,     !abort && c >= s && c <= wake_at + WAKE_DLY);
            chk("wake_pulse", wake_pulse,    !abort && c == e);
            chk("abort",      sleep_abort,   abort && c == e);
            if (c == e) chk("state_run", dut.state_q === ST_RUN, 1'b1);
            if (rst_at != 0 && c == rst_at) begin
                #2 greset = 1'b1;
                #1;
                chk("rst_goodnight", cpz_goodnight, 1'b0);
                chk("rst_sleep_ack", sleep_ack, 1'b0);
                chk("rst_state_run", dut.state_q === ST_RUN, 1'b1);
                @(posedge gfclk);
                #1 greset = 1'b0;
                clear_inputs();
                repeat (4) @(posedge gfclk);
                #1;
                return;
            end
            @(posedge gfclk);
            #1;
        end
        clear_inputs();
        repeat (2) @(posedge gfclk);
        #1;
    endtask

    initial begin
        int idle_at, wake_at, wake_len, scan_lo, scan_hi;
        logic [2:0] src;
        bit noise;

        clear_inputs();
        greset = 1'b0;
        #1 greset = 1'b1;
        #2;
        chk("reset_goodnight",  cpz_goodnight, 1'b0);
        chk("reset_sleep_ack",  sleep_ack,     1'b0);
        chk("reset_wake_pulse", wake_pulse,    1'b0);
        chk("reset_abort",      sleep_abort,   1'b0);
        chk("reset_state",      dut.state_q === ST_RUN, 1'b1);
        repeat (3) @(posedge gfclk);
        #1 greset = 1'b0;
        repeat (4) @(posedge gfclk);
        #1;
        chk("post_release_state", dut.state_q === ST_RUN, 1'b1);

        // Idle at the WAIT, interrupt at +10: gate at +2, release at +11, wake pulse at +15.
        episode(0, 10, 3, 3'b001, NEVER, 0, 1'b0, 0);
        // Bus busy, interrupt 3 cycles later: abort without ever gating.
        episode(NEVER, 3, 2, 3'b001, NEVER, 0, 1'b0, 0);
        // Idle and NMI in the same drain cycle: NMI wins.
        episode(2, 2, 2, 3'b010, NEVER, 0, 1'b0, 0);
        // Never idle: timeout build aborts after DRAIN_MAX, otherwise drain holds 100 cycles.
        episode(NEVER, 101, 1, 3'b001, NEVER, 0, 1'b0, 0);
        // Scan during sleep masks the gate request only.
        episode(1, 15, 2, 3'b100, 4, 7, 1'b0, 0);
        // Single-cycle debug request still runs the full wake delay; stray WAITs ignored.
        episode(3, 6, 1, 3'b100, NEVER, 0, 1'b1, 0);
        // Reset between edges while asleep.
        episode(1, 20, 2, 3'b001, NEVER, 0, 1'b0, 6);

        for (int i = 0; i < 40; i++) begin
            idle_at  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 12);
            wake_at  = $urandom_range(1, 30);
            wake_len = $urandom_range(1, 6);
            src      = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1) begin
                scan_lo = $urandom_range(0, 20);
                scan_hi = scan_lo + $urandom_range(0, 5);
            end else begin
                scan_lo = NEVER;
                scan_hi = 0;
            end
            noise = 1'($urandom_range(0, 1));
            episode(idle_at, wake_at, wake_len, src, scan_lo, scan_hi, noise, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
